// File: rtl/mux_add_param.sv
// rtl/mux_add_param.sv - mux-based scaled adder for unary bitstreams, internal round-robin/LFSR select
// Optional ones counter: define MUXADD_OCNT_EN to add the ocnt/ocnt_clr ports.
module mux_add_param #(
  parameter int INUM    = 8,
  parameter int LOGINUM = $clog2(INUM),
  parameter int CWIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [LOGINUM-1:0] sel_ext,
  input  logic [INUM-1:0]    in,
  output logic               out,
  output logic               out_valid,
  output logic [LOGINUM-1:0] sel_cur
`ifdef MUXADD_OCNT_EN
  ,
  input  logic               ocnt_clr,
  output logic [CWIDTH-1:0]  ocnt
`endif
);

  // Maximal-length feedback taps (bit positions of lf) for LOGINUM 2..8.
  function automatic logic [7:0] taps_for(input int n);
    case (n)
      2:       taps_for = 8'b0000_0011;
      3:       taps_for = 8'b0000_0110;
      4:       taps_for = 8'b0000_1100;
      5:       taps_for = 8'b0001_0100;
      6:       taps_for = 8'b0011_0000;
      7:       taps_for = 8'b0110_0000;
      8:       taps_for = 8'b1011_1000;
      default: taps_for = 8'b0000_0001;
    endcase
  endfunction

  localparam logic [7:0] TAPS = taps_for(LOGINUM);

  logic [LOGINUM-1:0] rr;
  logic [LOGINUM-1:0] lf;
  logic [LOGINUM-1:0] lf_next;
  logic [LOGINUM-1:0] s;
  logic               bit_sel;

  always_comb begin
    s = rr;
    case (mode)
      2'b00:   s = sel_ext;
      2'b10:   s = lf;
      default: s = rr;
    endcase
  end

  assign bit_sel = in[s];

  // The all-zero-low-bits term splices state 0 into the cycle (de Bruijn).
  generate
    if (LOGINUM == 1) begin : g_lf1
      assign lf_next = ~lf;
    end else begin : g_lfn
      assign lf_next = {lf[LOGINUM-2:0],
                        (^(lf & TAPS[LOGINUM-1:0])) ^ (lf[LOGINUM-2:0] == '0)};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
      sel_cur   <= '0;
      rr        <= '0;
      lf        <= LOGINUM'(1);
    end else begin
      out_valid <= en;
      if (en) begin
        out     <= bit_sel;
        sel_cur <= s;
        if (mode == 2'b10)
          lf <= lf_next;
        else if (mode != 2'b00)
          rr <= rr + LOGINUM'(1);
      end
    end
  end

`ifdef MUXADD_OCNT_EN
  logic one_emitted;
  assign one_emitted = en & bit_sel;

  always_ff @(posedge clk) begin
    if (rst)
      ocnt <= '0;
    else if (ocnt_clr)
      ocnt <= one_emitted ? CWIDTH'(1) : '0;
    else if (one_emitted && (ocnt != {CWIDTH{1'b1}}))
      ocnt <= ocnt + CWIDTH'(1);
  end
`endif

endmodule
